// File: rtl/riscv_pkg.sv
// riscv_pkg: state, opcode and datapath-select encodings shared by the multicycle control FSM
package riscv_pkg;
  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMRD    = 4'd3,
    MEMWB    = 4'd4,
    MEMWR    = 4'd5,
    EXEC_R   = 4'd6,
    EXEC_I   = 4'd7,
    LUI      = 4'd8,
    ALUWB    = 4'd9,
    BRANCH   = 4'd10,
    JAL      = 4'd11,
    JALR     = 4'd12,
    JALR_LNK = 4'd13,
    TRAP     = 4'd14
  } mc_state_e;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;
  localparam logic [1:0] SRCA_ZERO  = 2'b11;
  localparam logic [1:0] SRCB_RS2   = 2'b00;
  localparam logic [1:0] SRCB_IMM   = 2'b01;
  localparam logic [1:0] SRCB_FOUR  = 2'b10;
  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_RDATA  = 2'b01;
  localparam logic [1:0] RES_ALURES = 2'b10;
  localparam logic [1:0] ALU_ADD    = 2'b00;
  localparam logic [1:0] ALU_SUB    = 2'b01;
  localparam logic [1:0] ALU_FUNCT  = 2'b10;
  function automatic mc_state_e decode_next(input logic [6:0] op);
    case (op)
      OP_LOAD, OP_STORE: return MEMADR;
      OP_R:              return EXEC_R;
      OP_I:              return EXEC_I;
      OP_BRANCH:         return BRANCH;
      OP_JAL:            return JAL;
      OP_JALR:           return JALR;
      OP_LUI:            return LUI;
      OP_AUIPC:          return ALUWB;
      default:           return TRAP;
    endcase
  endfunction
endpackage

// File: rtl/mc_bus_timer.sv
// mc_bus_timer: counts non-ready cycles of a memory request and flags expiry on the N-th one
module mc_bus_timer #(
  parameter int N = 4
) (
  input  logic clk_i,
  input  logic rstn_i,
  input  logic req_i,
  input  logic ready_i,
  output logic expired_o
);
  localparam int W = N > 1 ? $clog2(N) : 1;
  logic [W-1:0] cnt;
  assign expired_o = req_i && !ready_i && cnt == W'(N - 1);
  always_ff @(posedge clk_i or negedge rstn_i)
    if (!rstn_i) cnt <= '0;
    else cnt <= (req_i && !ready_i && !expired_o) ? cnt + W'(1) : '0;
endmodule

// File: rtl/riscv_mc_fsm.sv
// riscv_mc_fsm: multicycle RISC-V main control FSM (mem req/ready handshake, bus timeout, sticky trap, instret)
module riscv_mc_fsm
  import riscv_pkg::*;
#(
  parameter int CNT_W       = 32,
  parameter int MEM_TIMEOUT = 0
) (
  input  logic             clk_i,
  input  logic             rstn_i,
  input  logic [6:0]       opcode_i,
  input  logic             branch_i,
  input  logic             mem_ready_i,
  output logic             mem_req_o,
  output logic             mem_we_o,
  output logic             AdrSrc_o,
  output logic             PCWrite_o,
  output logic             IRWrite_o,
  output logic             RegWrite_o,
  output logic [1:0]       ALUSrcA_o,
  output logic [1:0]       ALUSrcB_o,
  output logic [1:0]       ALUOp_o,
  output logic [1:0]       ResultSrc_o,
  output logic             trap_o,
  output logic             trap_cause_o,
  output logic [CNT_W-1:0] instret_o,
  output logic [3:0]       state_o
);
  mc_state_e state, state_nx;
  logic req, expired, retire;
  assign req = state inside {FETCH, MEMRD, MEMWR};
  generate
    if (MEM_TIMEOUT > 0) begin : g_timer
      mc_bus_timer #(.N(MEM_TIMEOUT)) u_timer (
        .clk_i    (clk_i),
        .rstn_i   (rstn_i),
        .req_i    (req),
        .ready_i  (mem_ready_i),
        .expired_o(expired)
      );
    end else begin : g_no_timer
      assign expired = 1'b0;
    end
  endgenerate
  always_comb begin
    state_nx = state;
    retire = 1'b0;
    case (state)
      FETCH:  state_nx = mem_ready_i ? DECODE : expired ? TRAP : FETCH;
      DECODE: state_nx = decode_next(opcode_i);
      MEMADR: state_nx = opcode_i[5] ? MEMWR : MEMRD;
      MEMRD:  state_nx = mem_ready_i ? MEMWB : expired ? TRAP : MEMRD;
      MEMWR: begin
        state_nx = mem_ready_i ? FETCH : expired ? TRAP : MEMWR;
        retire = mem_ready_i;
      end
      MEMWB, ALUWB, BRANCH, JALR_LNK: begin
        state_nx = FETCH;
        retire = 1'b1;
      end
      EXEC_R, EXEC_I, LUI, JAL: state_nx = ALUWB;
      JALR:    state_nx = JALR_LNK;
      default: state_nx = TRAP;
    endcase
  end
  always_ff @(posedge clk_i or negedge rstn_i)
    if (!rstn_i) begin
      state <= FETCH;
      trap_cause_o <= 1'b0;
      instret_o <= '0;
    end else begin
      state <= state_nx;
      if (state_nx == TRAP && state != TRAP) trap_cause_o <= state != DECODE;
      if (retire) instret_o <= instret_o + CNT_W'(1);
    end
  always_comb begin
    mem_we_o = 1'b0;
    AdrSrc_o = 1'b0;
    PCWrite_o = 1'b0;
    IRWrite_o = 1'b0;
    RegWrite_o = 1'b0;
    ALUSrcA_o = SRCA_PC;
    ALUSrcB_o = SRCB_RS2;
    ALUOp_o = ALU_ADD;
    ResultSrc_o = RES_ALUOUT;
    case (state)
      FETCH: begin
        ALUSrcB_o = SRCB_FOUR;
        ResultSrc_o = RES_ALURES;
        IRWrite_o = mem_ready_i;
        PCWrite_o = mem_ready_i;
      end
      DECODE: begin
        ALUSrcA_o = SRCA_OLDPC;
        ALUSrcB_o = SRCB_IMM;
      end
      MEMADR: begin
        ALUSrcA_o = SRCA_RS1;
        ALUSrcB_o = SRCB_IMM;
      end
      MEMRD: AdrSrc_o = 1'b1;
      MEMWB: begin
        ResultSrc_o = RES_RDATA;
        RegWrite_o = 1'b1;
      end
      MEMWR: begin
        mem_we_o = 1'b1;
        AdrSrc_o = 1'b1;
      end
      EXEC_R: begin
        ALUSrcA_o = SRCA_RS1;
        ALUOp_o = ALU_FUNCT;
      end
      EXEC_I: begin
        ALUSrcA_o = SRCA_RS1;
        ALUSrcB_o = SRCB_IMM;
        ALUOp_o = ALU_FUNCT;
      end
      LUI: begin
        ALUSrcA_o = SRCA_ZERO;
        ALUSrcB_o = SRCB_IMM;
      end
      ALUWB: RegWrite_o = 1'b1;
      BRANCH: begin
        ALUSrcA_o = SRCA_RS1;
        ALUOp_o = ALU_SUB;
        PCWrite_o = branch_i;
      end
      JAL: begin
        ALUSrcA_o = SRCA_OLDPC;
        ALUSrcB_o = SRCB_FOUR;
        PCWrite_o = 1'b1;
      end
      JALR: begin
        ALUSrcA_o = SRCA_RS1;
        ALUSrcB_o = SRCB_IMM;
        ResultSrc_o = RES_ALURES;
        PCWrite_o = 1'b1;
      end
      JALR_LNK: begin
        ALUSrcA_o = SRCA_OLDPC;
        ALUSrcB_o = SRCB_FOUR;
        ResultSrc_o = RES_ALURES;
        RegWrite_o = 1'b1;
      end
      default: ;
    endcase
  end
  // request is dropped combinationally while reset is held so an aborted access never looks valid
  assign mem_req_o = req && rstn_i;
  assign trap_o = state == TRAP;
  assign state_o = state;
endmodule

// File: tb/tb_riscv_mc_fsm.sv
// tb_riscv_mc_fsm: randomized instruction stream checked against a per-instruction phase model
module tb_riscv_mc_fsm;
  import riscv_pkg::*;
  localparam int TO = 4;
  logic clk = 1'b0;
  logic rstn_i = 1'b1;
  logic [6:0] opcode_i = '0;
  logic branch_i = 1'b0;
  logic mem_ready_i = 1'b0;
  logic mem_req_o, mem_we_o, AdrSrc_o, PCWrite_o, IRWrite_o, RegWrite_o, trap_o, trap_cause_o;
  logic [1:0] ALUSrcA_o, ALUSrcB_o, ALUOp_o, ResultSrc_o;
  logic [3:0] instret_o, state_o;
  int passed = 0, total = 0, inst_cnt = 0;
  mc_state_e q[$];
  mc_state_e end_st;
  logic exp_cause;
  logic [6:0] ops [9] = '{OP_LOAD, OP_STORE, OP_R, OP_I, OP_BRANCH, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC};
  always #5 clk = ~clk;
  riscv_mc_fsm #(.CNT_W(4), .MEM_TIMEOUT(TO)) dut (
    .clk_i(clk), .rstn_i(rstn_i), .opcode_i(opcode_i), .branch_i(branch_i), .mem_ready_i(mem_ready_i),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .AdrSrc_o(AdrSrc_o), .PCWrite_o(PCWrite_o),
    .IRWrite_o(IRWrite_o), .RegWrite_o(RegWrite_o), .ALUSrcA_o(ALUSrcA_o), .ALUSrcB_o(ALUSrcB_o),
    .ALUOp_o(ALUOp_o), .ResultSrc_o(ResultSrc_o), .trap_o(trap_o), .trap_cause_o(trap_cause_o),
    .instret_o(instret_o), .state_o(state_o)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask
  // {req, we, adrsrc, srca, srcb, aluop, resultsrc, trap} as tabulated for each phase
  function automatic logic [12:0] moore(input mc_state_e s);
    case (s)
      FETCH:    return 13'b100_00_10_00_10_0;
      DECODE:   return 13'b000_01_01_00_00_0;
      MEMADR:   return 13'b000_10_01_00_00_0;
      MEMRD:    return 13'b101_00_00_00_00_0;
      MEMWB:    return 13'b000_00_00_00_01_0;
      MEMWR:    return 13'b111_00_00_00_00_0;
      EXEC_R:   return 13'b000_10_00_10_00_0;
      EXEC_I:   return 13'b000_10_01_10_00_0;
      LUI:      return 13'b000_11_01_00_00_0;
      ALUWB:    return 13'b000_00_00_00_00_0;
      BRANCH:   return 13'b000_10_00_01_00_0;
      JAL:      return 13'b000_01_10_00_00_0;
      JALR:     return 13'b000_10_01_00_10_0;
      JALR_LNK: return 13'b000_01_10_00_10_0;
      default:  return 13'b000_00_00_00_00_1;
    endcase
  endfunction
  // a request phase lasts wait+1 cycles, or TO cycles if the memory is slower than the timeout
  function automatic bit push_req(input mc_state_e s, input int w);
    repeat (w < TO ? w + 1 : TO) q.push_back(s);
    return w < TO;
  endfunction
  task automatic build(input logic [6:0] op, input int fw, input int mw);
    q.delete();
    end_st = FETCH;
    exp_cause = 1'b0;
    if (!push_req(FETCH, fw)) begin
      end_st = TRAP;
      exp_cause = 1'b1;
      return;
    end
    q.push_back(DECODE);
    case (op)
      OP_LOAD: begin
        q.push_back(MEMADR);
        if (push_req(MEMRD, mw)) q.push_back(MEMWB);
        else begin end_st = TRAP; exp_cause = 1'b1; end
      end
      OP_STORE: begin
        q.push_back(MEMADR);
        if (!push_req(MEMWR, mw)) begin end_st = TRAP; exp_cause = 1'b1; end
      end
      OP_R:      begin q.push_back(EXEC_R); q.push_back(ALUWB); end
      OP_I:      begin q.push_back(EXEC_I); q.push_back(ALUWB); end
      OP_LUI:    begin q.push_back(LUI); q.push_back(ALUWB); end
      OP_AUIPC:  q.push_back(ALUWB);
      OP_BRANCH: q.push_back(BRANCH);
      OP_JAL:    begin q.push_back(JAL); q.push_back(ALUWB); end
      OP_JALR:   begin q.push_back(JALR); q.push_back(JALR_LNK); end
      default:   end_st = TRAP;
    endcase
  endtask
  task automatic run(input logic [6:0] op, input int fw, input int mw, input int brm);
    mc_state_e s, nx;
    logic rdy, br;
    build(op, fw, mw);
    foreach (q[i]) begin
      @(negedge clk);
      s = q[i];
      nx = (i + 1 < q.size()) ? q[i+1] : end_st;
      rdy = (s inside {FETCH, MEMRD, MEMWR}) ? (nx != s && nx != TRAP) : 1'($urandom);
      br = brm < 0 ? 1'($urandom) : 1'(brm);
      opcode_i = op;
      branch_i = br;
      mem_ready_i = rdy;
      #1;
      chk("state", state_o, s);
      chk("moore", {mem_req_o, mem_we_o, AdrSrc_o, ALUSrcA_o, ALUSrcB_o, ALUOp_o, ResultSrc_o, trap_o}, moore(s));
      chk("pcwrite", PCWrite_o, (s == FETCH && rdy) || (s == BRANCH && br) || s == JAL || s == JALR);
      chk("irwrite", IRWrite_o, s == FETCH && rdy);
      chk("regwrite", RegWrite_o, s inside {MEMWB, ALUWB, JALR_LNK});
    end
    @(posedge clk);
    #1;
    if (end_st == FETCH) inst_cnt = (inst_cnt + 1) % 16;
    chk("end_state", state_o, end_st);
    chk("instret", instret_o, inst_cnt);
    chk("trap", trap_o, end_st == TRAP);
    chk("cause", trap_cause_o, exp_cause);
  endtask
  task automatic trap_hold();
    repeat (20) begin
      @(negedge clk);
      opcode_i = 7'($urandom);
      branch_i = 1'($urandom);
      mem_ready_i = 1'($urandom);
      #1;
      chk("trap_state", state_o, TRAP);
      chk("trap_outs", {mem_req_o, mem_we_o, AdrSrc_o, ALUSrcA_o, ALUSrcB_o, ALUOp_o, ResultSrc_o, trap_o,
                        PCWrite_o, IRWrite_o, RegWrite_o}, {moore(TRAP), 3'b000});
    end
  endtask
  task automatic do_reset();
    @(posedge clk);
    #2 rstn_i = 1'b0;
    mem_ready_i = 1'b0;
    #1;
    chk("rst_req", mem_req_o, 0);
    chk("rst_state", state_o, FETCH);
    chk("rst_instret", instret_o, 0);
    chk("rst_trap", trap_o, 0);
    chk("rst_cause", trap_cause_o, 0);
    @(posedge clk);
    #2 rstn_i = 1'b1;
    #1;
    chk("post_rst_req", mem_req_o, 1);
    inst_cnt = 0;
  endtask
  initial begin
    do_reset();
    run(OP_R, 0, 0, -1);
    run(OP_LOAD, 3, 2, -1);
    run(OP_BRANCH, 0, 0, 0);
    run(OP_BRANCH, 0, 0, 1);
    run(OP_STORE, 1, 1, -1);
    run(OP_JAL, 0, 0, -1);
    run(OP_JALR, 2, 0, -1);
    run(OP_LUI, 0, 0, -1);
    run(OP_AUIPC, 0, 0, -1);
    run(OP_I, 3, 0, -1);
    repeat (60) run(ops[$urandom_range(0, 8)], $urandom_range(0, 3), $urandom_range(0, 3), -1);
    do_reset();
    for (int i = 0; i < 16; i++) begin
      run(i[0] ? OP_I : OP_R, 0, 0, -1);
      if (i == 14) chk("pre_wrap", instret_o, 15);
    end
    chk("wrap", instret_o, 0);
    run(7'b1111111, 0, 0, -1);
    trap_hold();
    do_reset();
    run(OP_R, 99, 0, -1);
    trap_hold();
    do_reset();
    run(OP_R, 3, 0, -1);
    run(OP_LOAD, 0, 99, -1);
    trap_hold();
    do_reset();
    run(OP_STORE, 2, 3, -1);
    run(OP_STORE, 0, 4, -1);
    do_reset();
    run(OP_JALR, 0, 0, -1);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
